// File: rtl/mmio_pkg.sv
// Shared address map defaults, character field offsets and status-register layout
// for the MMIO bridge.
package mmio_pkg;

    localparam int unsigned DEF_DMEM_WORDS    = 4096;
    localparam int unsigned DEF_KBD_ADDR      = 4100;
    localparam int unsigned DEF_KBD_STAT_ADDR = 4101;
    localparam int unsigned DEF_CHAR_BASE     = 4200;

    localparam int unsigned N_FIELDS = 3;
    localparam logic [1:0]  FLD_X    = 2'd0;
    localparam logic [1:0]  FLD_Y    = 2'd1;
    localparam logic [1:0]  FLD_VEL  = 2'd2;

    // Status register: bit 0 = FIFO empty, bits 7:1 = FIFO occupancy.
    localparam int unsigned STAT_EMPTY_BIT = 0;
    localparam int unsigned STAT_CNT_LSB   = 1;
    localparam int unsigned STAT_CNT_W     = 7;

    function automatic logic [31:0] char_addr(input int unsigned base,
                                              input int unsigned idx,
                                              input int unsigned fld);
        return 32'(base + N_FIELDS * idx + fld);
    endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Scan-code FIFO: drops pushes while full (flagging overflow) unless a pop frees
// a slot in the same cycle.
module kbd_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow_pulse
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty          = (count_q == '0);
    assign full           = (count_q == FULL_CNT);
    assign count          = count_q;
    assign dout           = mem_q[rd_ptr_q];
    assign do_pop         = pop && !empty;
    assign do_push        = push && (!full || do_pop);
    assign overflow_pulse = push && full && !do_pop;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/mmio_bridge.sv
// Processor data-port bridge: dmem write gating, PS/2 scan-code buffering,
// per-character x/y/vel registers and a single registered read-data path.
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter int unsigned DMEM_WORDS    = DEF_DMEM_WORDS,
    parameter int unsigned KBD_ADDR      = DEF_KBD_ADDR,
    parameter int unsigned KBD_STAT_ADDR = DEF_KBD_STAT_ADDR,
    parameter int unsigned CHAR_BASE     = DEF_CHAR_BASE,
    parameter int unsigned N_CHAR        = 4,
    parameter int unsigned KBD_DEPTH     = 8,
    parameter int unsigned X_INIT        = 240,
    parameter int unsigned Y_INIT        = 240,
    parameter int unsigned VEL_INIT      = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [16:0]             address_dmem,
    input  logic [31:0]             data,
    input  logic                    wren,
    input  logic [31:0]             q_dmem,
    output logic                    real_wren,
    input  logic                    ps2_key_pressed,
    input  logic [7:0]              ps2_out,
    output logic [31:0]             proc_data_in,
    output logic                    isKeyboardLoad,
    output logic                    kbd_overflow,
    output logic [32*N_CHAR-1:0]    char_x,
    output logic [32*N_CHAR-1:0]    char_y,
    output logic [32*N_CHAR-1:0]    char_vel
);

    localparam int unsigned AW = $clog2(KBD_DEPTH);
    localparam int unsigned IW = (N_CHAR > 1) ? $clog2(N_CHAR) : 1;

    logic [31:0]   addr32;
    logic          rd_kbd, wr_stat;
    logic          key_q, kbd_push, kbd_pop;
    logic [7:0]    kbd_dout;
    logic          kbd_empty, kbd_full, kbd_ovf_pulse;
    logic [AW:0]   kbd_count;
    logic          char_hit;
    logic [IW-1:0] char_idx;
    logic [1:0]    char_fld;
    logic [31:0]   char_rd, stat_word;
    logic [31:0]   rdata_d, rdata_q;
    logic          kbd_load_q, ovf_q;
    logic [31:0]   x_q   [N_CHAR];
    logic [31:0]   y_q   [N_CHAR];
    logic [31:0]   vel_q [N_CHAR];

    assign addr32    = {15'd0, address_dmem};
    assign real_wren = wren && (addr32 < DMEM_WORDS);
    assign rd_kbd    = (addr32 == KBD_ADDR) && !wren;
    assign wr_stat   = (addr32 == KBD_STAT_ADDR) && wren;
    assign kbd_push  = ps2_key_pressed && !key_q;
    assign kbd_pop   = rd_kbd && !kbd_empty;

    kbd_fifo #(
        .WIDTH (8),
        .DEPTH (KBD_DEPTH)
    ) u_kbd_fifo (
        .clk            (clock),
        .rst_n          (reset),
        .push           (kbd_push),
        .din            (ps2_out),
        .pop            (kbd_pop),
        .dout           (kbd_dout),
        .empty          (kbd_empty),
        .full           (kbd_full),
        .count          (kbd_count),
        .overflow_pulse (kbd_ovf_pulse)
    );

    // Decode by exact match over the register map rather than divide-by-3.
    always_comb begin
        char_hit = 1'b0;
        char_idx = '0;
        char_fld = FLD_X;
        for (int unsigned i = 0; i < N_CHAR; i++) begin
            for (int unsigned f = 0; f < N_FIELDS; f++) begin
                if (addr32 == char_addr(CHAR_BASE, i, f)) begin
                    char_hit = 1'b1;
                    char_idx = IW'(i);
                    char_fld = 2'(f);
                end
            end
        end
    end

    always_comb begin
        case (char_fld)
            FLD_X:   char_rd = x_q[char_idx];
            FLD_Y:   char_rd = y_q[char_idx];
            default: char_rd = vel_q[char_idx];
        endcase
    end

    always_comb begin
        stat_word = '0;
        stat_word[STAT_EMPTY_BIT] = kbd_empty;
        stat_word[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(kbd_count);
    end

    always_comb begin
        rdata_d = '0;
        if (addr32 < DMEM_WORDS)            rdata_d = q_dmem;
        else if (addr32 == KBD_ADDR)        rdata_d = kbd_empty ? '0 : 32'(kbd_dout);
        else if (addr32 == KBD_STAT_ADDR)   rdata_d = stat_word;
        else if (char_hit)                  rdata_d = char_rd;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata_q    <= '0;
            kbd_load_q <= 1'b0;
            ovf_q      <= 1'b0;
            key_q      <= 1'b0;
        end else begin
            if (!wren) rdata_q <= rdata_d;
            kbd_load_q <= rd_kbd;
            key_q      <= ps2_key_pressed;
            if (kbd_ovf_pulse)  ovf_q <= 1'b1;
            else if (wr_stat)   ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < N_CHAR; i++) begin
                x_q[i]   <= X_INIT;
                y_q[i]   <= Y_INIT;
                vel_q[i] <= VEL_INIT;
            end
        end else if (wren && char_hit) begin
            case (char_fld)
                FLD_X:   x_q[char_idx]   <= data;
                FLD_Y:   y_q[char_idx]   <= data;
                default: vel_q[char_idx] <= data;
            endcase
        end
    end

    always_comb begin
        char_x   = '0;
        char_y   = '0;
        char_vel = '0;
        for (int unsigned i = 0; i < N_CHAR; i++) begin
            char_x[32*i +: 32]   = x_q[i];
            char_y[32*i +: 32]   = y_q[i];
            char_vel[32*i +: 32] = vel_q[i];
        end
    end

    assign proc_data_in   = rdata_q;
    assign isKeyboardLoad = kbd_load_q;
    assign kbd_overflow   = ovf_q;

    a_full_count : assert property (@(posedge clock) disable iff (!reset)
        kbd_full |-> (kbd_count == (AW + 1)'(KBD_DEPTH)));

endmodule

// File: doc/mmio_bridge.md
Name: mmio_bridge

Overview:
- Parametrised memory-mapped I/O bridge between the processor's data port, the 4096-word dmem and game peripherals.
- Decodes each processor data access and gates dmem writes. Buffers PS/2 scan codes in a FIFO and holds N_CHAR character register sets (x, y, vel). Returns all read data through one registered proc_data_in path.
- Replaces the single-player, single-scan-code scheme with multi-character storage, keyboard buffering, a status register and overflow reporting.

Parameters:
- DMEM_WORDS, 4096: dmem size; addresses 0..DMEM_WORDS-1 map to dmem.
- KBD_ADDR, 4100: keyboard data register (read pops the FIFO).
- KBD_STAT_ADDR, 4101: keyboard status register.
- CHAR_BASE, 4200: first character register. Character i, field f (0=x, 1=y, 2=vel) is at CHAR_BASE+3*i+f.
- N_CHAR, 4: number of characters, 1..16.
- KBD_DEPTH, 8: FIFO depth, a power of two, 2..64.
- X_INIT, 240 / Y_INIT, 240 / VEL_INIT, 0: reset values of every character register.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- address_dmem  in  17  processor data address.
- data  in  32  processor write data.
- wren  in  1  processor write enable.
- q_dmem  in  32  dmem read data, valid in the same cycle.
- real_wren  out  1  dmem write enable, combinational.
- ps2_key_pressed  in  1  PS/2 key strobe, level signal.
- ps2_out  in  8  PS/2 scan code.
- proc_data_in  out  32  registered read data to the processor.
- isKeyboardLoad  out  1  registered; 1 on the cycle after a KBD_ADDR read.
- kbd_overflow  out  1  sticky FIFO-overflow flag.
- char_x  out  32*N_CHAR  x of all characters; character i in bits [32i+31:32i].
- char_y  out  32*N_CHAR  y of all characters, same packing.
- char_vel  out  32*N_CHAR  vel of all characters, same packing.

Behaviour:
- Reset (reset=0, asynchronous):
  - proc_data_in=0, isKeyboardLoad=0, kbd_overflow=0.
  - FIFO empty; pointers and count 0; edge-detect register 0.
  - All char_x=X_INIT, char_y=Y_INIT, char_vel=VEL_INIT.
  - A reset during an access discards that access.
- real_wren = wren when address_dmem < DMEM_WORDS, else 0. No other qualification.
- Read path: one-cycle latency. On posedge with wren=0, proc_data_in loads:
  - dmem range: q_dmem.
  - KBD_ADDR: FIFO head zero-extended to 32 bits; 0 if the FIFO is empty.
  - KBD_STAT_ADDR: {24'd0, count[6:0], empty}.
  - Character address in range: that register.
  - Any other address: 0.
- proc_data_in holds its value on write cycles.
- isKeyboardLoad <= (address_dmem==KBD_ADDR && wren==0); it is 0 in every other cycle.
- Writes (wren=1):
  - Character address: update that register on the posedge.
  - KBD_STAT_ADDR: clears kbd_overflow regardless of data.
  - KBD_ADDR and unmapped addresses: ignored.
  - A character address at or beyond CHAR_BASE+3*N_CHAR is unmapped: reads return 0, writes are ignored.
- Keyboard FIFO:
  - Push: ps2_out is pushed on the first cycle ps2_key_pressed is seen 1 after being 0 (registered edge detect). A held strobe pushes once.
  - Pop: every cycle with address_dmem==KBD_ADDR, wren=0 and FIFO not empty. A read while empty returns 0 and does not pop.
  - Push while full and no pop in that cycle: the code is dropped, kbd_overflow is set, contents are unchanged.
  - Push and pop in the same cycle: both occur. Count is unchanged. When full this is not an overflow.
  - When empty, the pushed code is not visible to a pop in the same cycle; the read returns 0.
  - Pointers are log2(KBD_DEPTH) bits wide and wrap naturally; count is log2(KBD_DEPTH)+1 bits wide.
  - If clearing and setting kbd_overflow coincide in one cycle, setting wins.

Decomposition:
- Package mmio_pkg: default address constants, field offsets FLD_X=0, FLD_Y=1, FLD_VEL=2, and the status-register bit layout.
- Sub-module kbd_fifo (parameters WIDTH=8, DEPTH): push, pop, dout, empty, full, count, overflow_pulse.
- Edge detect, address decode, character register array and read mux stay in the top level.

Test Plan:
- Reset, then read 4200, 4201, 4202 and 4211 (N_CHAR=4) -> proc_data_in = 240, 240, 0, 0 respectively, each one cycle after the address.
- Write 123 to 4205 (character 1 vel), then read it back -> char_vel[63:32]=123 and proc_data_in=123; other characters unchanged. Write to 5000 -> no effect, real_wren=0.
- Write address 100 with wren=1 -> real_wren=1. Address 4096 with wren=1 -> real_wren=0. Read address 100 with q_dmem=0xDEADBEEF -> proc_data_in=0xDEADBEEF next cycle.
- Strobe keys 0x1C, 0x1B, holding ps2_key_pressed 3 cycles each. Read 4101 -> 4 (count=2, empty=0). Read 4100 twice -> 0x1C then 0x1B, isKeyboardLoad=1 for each. Read 4100 again -> 0, count stays 0.
- Push 9 codes with KBD_DEPTH=8 -> kbd_overflow=1 and the 9th code is lost. Write 4101 -> kbd_overflow=0. With the FIFO full, push and pop in the same cycle -> count stays 8 and no overflow.
- Drive reset=0 mid-stream with 3 codes buffered and character registers modified -> asynchronous clear to the reset values before the next posedge; FIFO empty.
